// File: rtl/mem_wb_writeback_pkg.sv
// Shared constants for the MEM/WB writeback slice: data width,
// the $0 register number, load-type codes and extend helpers.
package mem_wb_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG0 = '0;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  function automatic logic [DATA_W-1:0] ext8(
    input logic [7:0] b,
    input logic       sgn
  );
    return {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext16(
    input logic [15:0] h,
    input logic        sgn
  );
    return {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Load aligner: picks the byte/halfword lane of a read word and
// sign- or zero-extends it; unknown codes pass the word through.
// Ports: rdata_i word, lane_i addr[1:0], ltype_i code, data_o result.
module mem_wb_writeback_load_align
  import mem_wb_writeback_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        ltype_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[7:0];
    unique case (lane_i)
      2'd0: byte_w = rdata_i[7:0];
      2'd1: byte_w = rdata_i[15:8];
      2'd2: byte_w = rdata_i[23:16];
      2'd3: byte_w = rdata_i[31:24];
    endcase
  end

  assign half_w = lane_i[1] ? rdata_i[31:16]
                            : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (ltype_i)
      LT_LB:   data_o = ext8(byte_w, 1'b1);
      LT_LBU:  data_o = ext8(byte_w, 1'b0);
      LT_LH:   data_o = ext16(half_w, 1'b1);
      LT_LHU:  data_o = ext16(half_w, 1'b0);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB register, writeback mux and retired-write counter.
// Ports: Writeback_CLK/RST(async low)/Stall/Flush, M-stage inputs
// (RegWrite, MemtoReg, LoadType, ALUOut, ReadData, WriteReg),
// regfile port WE3/A3/WD3 and RetireCount.
// Macro WB_PARTIAL_LOAD_EN enables byte/halfword load alignment.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int ADDR_Nbits = 5
) (
  input  logic                       Writeback_CLK,
  input  logic                       Writeback_RST,
  input  logic                       Writeback_Stall,
  input  logic                       Writeback_Flush,
  input  logic                       Writeback_RegWriteM,
  input  logic                       Writeback_MemtoRegM,
  input  logic [2:0]                 Writeback_LoadTypeM,
  input  logic [2**ADDR_Nbits-1:0]   Writeback_ALUOutM,
  input  logic [2**ADDR_Nbits-1:0]   Writeback_ReadDataM,
  input  logic [ADDR_Nbits-1:0]      Writeback_WriteRegM,
  output logic                       Writeback_WE3,
  output logic [ADDR_Nbits-1:0]      Writeback_A3,
  output logic [2**ADDR_Nbits-1:0]   Writeback_WD3,
  output logic [31:0]                Writeback_RetireCount
);

  localparam int DW = 2**ADDR_Nbits;

  logic                  rw_q, rw_d;
  logic                  m2r_q, m2r_d;
  logic [DW-1:0]         alu_q, alu_d;
  logic [DW-1:0]         rd_q, rd_d;
  logic [ADDR_Nbits-1:0] wr_q, wr_d;
  logic [31:0]           retire_q;
  logic [DW-1:0]         load_data;
  logic                  we3;

`ifdef WB_PARTIAL_LOAD_EN
  logic [2:0] lt_q, lt_d;
`else
  logic unused_lt;
  assign unused_lt = ^Writeback_LoadTypeM;
`endif

  // Flush beats Stall beats normal capture.
  always_comb begin
    rw_d  = rw_q;
    m2r_d = m2r_q;
    alu_d = alu_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
`ifdef WB_PARTIAL_LOAD_EN
    lt_d  = lt_q;
`endif
    if (Writeback_Flush) begin
      rw_d  = 1'b0;
      m2r_d = 1'b0;
      alu_d = '0;
      rd_d  = '0;
      wr_d  = '0;
`ifdef WB_PARTIAL_LOAD_EN
      lt_d  = LT_LW;
`endif
    end else if (!Writeback_Stall) begin
      rw_d  = Writeback_RegWriteM;
      m2r_d = Writeback_MemtoRegM;
      alu_d = Writeback_ALUOutM;
      rd_d  = Writeback_ReadDataM;
      wr_d  = Writeback_WriteRegM;
`ifdef WB_PARTIAL_LOAD_EN
      lt_d  = Writeback_LoadTypeM;
`endif
    end
  end

  always_ff @(posedge Writeback_CLK or negedge Writeback_RST) begin
    if (!Writeback_RST) begin
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
      alu_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
    end else begin
      rw_q  <= rw_d;
      m2r_q <= m2r_d;
      alu_q <= alu_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

`ifdef WB_PARTIAL_LOAD_EN
  always_ff @(posedge Writeback_CLK or negedge Writeback_RST) begin
    if (!Writeback_RST) lt_q <= LT_LW;
    else                lt_q <= lt_d;
  end

  mem_wb_writeback_load_align u_load_align (
    .rdata_i (rd_q),
    .lane_i  (alu_q[1:0]),
    .ltype_i (lt_q),
    .data_o  (load_data)
  );
`else
  assign load_data = rd_q;
`endif

  assign we3 = rw_q & (wr_q != ADDR_Nbits'(REG0));

  assign Writeback_WE3 = we3;
  assign Writeback_A3  = wr_q;
  assign Writeback_WD3 = m2r_q ? load_data : alu_q;

  // A stalled instruction is counted on the edge it leaves W.
  always_ff @(posedge Writeback_CLK or negedge Writeback_RST) begin
    if (!Writeback_RST)
      retire_q <= '0;
    else if (we3 && !Writeback_Stall)
      retire_q <= retire_q + 32'd1;
  end

  assign Writeback_RetireCount = retire_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: vector table plus
// hand sequences for async reset and counter wrap.
module tb_mem_wb_writeback;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, rw, m2r;
  logic [2:0]  lt;
  logic [31:0] alu, rd;
  logic [4:0]  wr;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3, cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mem_wb_writeback #(.ADDR_Nbits(5)) dut (
    .Writeback_CLK         (clk),
    .Writeback_RST         (rst_n),
    .Writeback_Stall       (stall),
    .Writeback_Flush       (flush),
    .Writeback_RegWriteM   (rw),
    .Writeback_MemtoRegM   (m2r),
    .Writeback_LoadTypeM   (lt),
    .Writeback_ALUOutM     (alu),
    .Writeback_ReadDataM   (rd),
    .Writeback_WriteRegM   (wr),
    .Writeback_WE3         (we3),
    .Writeback_A3          (a3),
    .Writeback_WD3         (wd3),
    .Writeback_RetireCount (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(
    input logic s, input logic f,
    input logic w, input logic m,
    input logic [2:0] t,
    input logic [31:0] a, input logic [31:0] r,
    input logic [4:0] d,
    input logic ew, input logic [4:0] ea,
    input logic [31:0] ed, input logic [31:0] ec
  );
    vec_t v;
    v.stall = s; v.flush = f; v.rw = w; v.m2r = m;
    v.lt = t; v.alu = a; v.rd = r; v.wr = d;
    v.e_we = ew; v.e_a3 = ea; v.e_wd = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall = 0; flush = 0; rw = 0; m2r = 0;
    lt = 3'b000; alu = '0; rd = '0; wr = '0;
  endtask

  localparam logic [31:0] RDW = 32'h80FF_7F01;

  initial begin
`ifdef WB_PARTIAL_LOAD_EN
    localparam logic [31:0] W7  = 32'hFFFF_FFFF;
    localparam logic [31:0] W8  = 32'h0000_007F;
    localparam logic [31:0] W9  = 32'hFFFF_80FF;
    localparam logic [31:0] W10 = 32'h0000_7F01;
    localparam logic [31:0] W12 = 32'h0000_0001;
`else
    localparam logic [31:0] W7  = RDW;
    localparam logic [31:0] W8  = RDW;
    localparam logic [31:0] W9  = RDW;
    localparam logic [31:0] W10 = RDW;
    localparam logic [31:0] W12 = RDW;
`endif
    //          s f w m lt      alu            rd   wr    we a3  wd              cnt
    vt[0]  = mk(0,0,1,0,3'b000, 32'h0000_1234, 0,   8,    1, 8,  32'h0000_1234, 0);
    vt[1]  = mk(0,0,1,0,3'b000, 32'h0000_5555, 0,   0,    0, 0,  32'h0000_5555, 1);
    vt[2]  = mk(0,0,1,0,3'b000, 32'hAAAA_0000, 0,   9,    1, 9,  32'hAAAA_0000, 1);
    vt[3]  = mk(1,0,1,0,3'b000, 32'h1,         0,   3,    1, 9,  32'hAAAA_0000, 1);
    vt[4]  = mk(1,0,1,0,3'b000, 32'h1,         0,   3,    1, 9,  32'hAAAA_0000, 1);
    vt[5]  = mk(1,0,1,0,3'b000, 32'h1,         0,   3,    1, 9,  32'hAAAA_0000, 1);
    vt[6]  = mk(0,0,0,0,3'b000, 32'h7,         0,   4,    0, 4,  32'h7,         2);
    vt[7]  = mk(0,0,1,1,3'b001, 32'h0000_0102, RDW, 10,   1, 10, W7,            2);
    vt[8]  = mk(0,0,1,1,3'b010, 32'h1,         RDW, 11,   1, 11, W8,            3);
    vt[9]  = mk(0,0,1,1,3'b011, 32'h2,         RDW, 12,   1, 12, W9,            4);
    vt[10] = mk(0,0,1,1,3'b100, 32'h0,         RDW, 13,   1, 13, W10,           5);
    vt[11] = mk(0,0,1,1,3'b101, 32'h3,         RDW, 14,   1, 14, RDW,           6);
    vt[12] = mk(0,0,1,1,3'b001, 32'h0,         RDW, 15,   1, 15, W12,           7);
    vt[13] = mk(1,1,1,0,3'b000, 32'h9,         0,   5,    0, 0,  32'h0,         7);
    vt[14] = mk(0,0,1,0,3'b000, 32'h66,        0,   6,    1, 6,  32'h66,        7);
    vt[15] = mk(0,1,1,0,3'b000, 32'h77,        0,   7,    0, 0,  32'h0,         8);
    vt[16] = mk(0,0,0,0,3'b000, 32'h0,         0,   0,    0, 0,  32'h0,         8);

    drive_idle();
    rst_n = 1'b0;
    #12;
    chk("reset_we3", {31'b0, we3}, 32'h0);
    chk("reset_a3",  {27'b0, a3}, 32'h0);
    chk("reset_wd3", wd3, 32'h0);
    chk("reset_cnt", cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First vector: outputs must not move before the edge.
    @(negedge clk);
    stall = vt[0].stall; flush = vt[0].flush;
    rw = vt[0].rw; m2r = vt[0].m2r; lt = vt[0].lt;
    alu = vt[0].alu; rd = vt[0].rd; wr = vt[0].wr;
    #1;
    chk("no_comb_we3", {31'b0, we3}, 32'h0);
    chk("no_comb_wd3", wd3, 32'h0);

    for (int i = 0; i < 17; i++) begin
      if (i != 0) begin
        @(negedge clk);
        stall = vt[i].stall; flush = vt[i].flush;
        rw = vt[i].rw; m2r = vt[i].m2r; lt = vt[i].lt;
        alu = vt[i].alu; rd = vt[i].rd; wr = vt[i].wr;
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we3", i), {31'b0, we3}, {31'b0, vt[i].e_we});
      chk($sformatf("v%0d_a3", i),  {27'b0, a3},  {27'b0, vt[i].e_a3});
      chk($sformatf("v%0d_wd3", i), wd3, vt[i].e_wd);
      chk($sformatf("v%0d_cnt", i), cnt, vt[i].e_cnt);
    end

    // Async reset mid-cycle with a pending write.
    @(negedge clk);
    drive_idle();
    rw = 1; alu = 32'hDEAD_BEEF; wr = 5'd8;
    @(posedge clk);
    #1;
    chk("pre_rst_we3", {31'b0, we3}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we3", {31'b0, we3}, 32'h0);
    chk("arst_wd3", wd3, 32'h0);
    chk("arst_cnt", cnt, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    @(posedge clk);
    #1;
    chk("wrap_pre", cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    rw = 1; alu = 32'h1; wr = 5'd1;
    @(posedge clk);
    #1;
    chk("wrap_we3", {31'b0, we3}, 32'h1);
    chk("wrap_hold", cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("wrap_zero", cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
